// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared state, opcode and select encodings for the multi-cycle controller
// Optional ERROR state is built only with MC_FSM_ILLEGAL_TRAP_EN.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    ,
    S_ERROR
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_RDATA    = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  // Must match the existing ALU decoder's ALU_op inputs.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

endpackage

// File: rtl/mc_main_fsm_if.sv
// rtl/mc_main_fsm_if.sv - controller <-> datapath signal bundle
// illegal_instr exists only with MC_FSM_ILLEGAL_TRAP_EN.
interface mc_main_fsm_if;

  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] ALU_op;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_write, adr_src,
    output alu_src_a, alu_src_b, result_src, ALU_op
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    , output illegal_instr
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_write, adr_src,
    input  alu_src_a, alu_src_b, result_src, ALU_op
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    , input illegal_instr
`endif
  );

endinterface

// File: rtl/mc_fsm_outputs.sv
// rtl/mc_fsm_outputs.sv - Moore output decode: selects and ungated strobes per state
// ERROR decode is built only with MC_FSM_ILLEGAL_TRAP_EN.
module mc_fsm_outputs
  import riscv_mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_BEQ: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.branch    = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_write  = 1'b1;
      end
`ifdef MC_FSM_ILLEGAL_TRAP_EN
      S_ERROR: ctrl.illegal = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multi-cycle RISC-V main control FSM with mem_ready stalls
// Define MC_FSM_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky ERROR state.
module mc_main_fsm
  import riscv_mc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mc_main_fsm_if.master bus
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
          default:      state_next = S_ERROR;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
      S_ERROR:    state_next = S_ERROR;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  mc_fsm_outputs u_outputs (
    .state (state),
    .ctrl  (ctrl)
  );

  // Raw ir_write marks FETCH, the only state whose pc_write waits on mem_ready.
  always_comb begin
    bus.alu_src_a  = ctrl.alu_src_a;
    bus.alu_src_b  = ctrl.alu_src_b;
    bus.result_src = ctrl.result_src;
    bus.ALU_op     = ctrl.alu_op;
    bus.adr_src    = ctrl.adr_src;
    bus.ir_write   = !reset && ctrl.ir_write && bus.mem_ready;
    bus.pc_write   = !reset && ((ctrl.pc_write && (!ctrl.ir_write || bus.mem_ready))
                                || (ctrl.branch && bus.zero));
    bus.reg_write  = !reset && ctrl.reg_write;
    bus.mem_write  = !reset && ctrl.mem_write;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    bus.illegal_instr = !reset && ctrl.illegal;
`endif
  end

endmodule
